// File: rtl/regfile_dec_pkg.sv
// rtl/regfile_dec_pkg.sv - shared widths, row types and one-hot check for the register-file write decoder
package regfile_dec_pkg;

    localparam int DEF_SEL_W = 5;
    localparam int NREG      = 2 ** DEF_SEL_W;
    localparam int MAX_ROWS  = 256;

    typedef logic [DEF_SEL_W-1:0] reg_idx_t;
    typedef logic [NREG-1:0]      reg_row_t;

    // Rows narrower than MAX_ROWS are zero-extended by the caller.
    function automatic logic onehot_ok(input logic [MAX_ROWS-1:0] row);
        return (row & (row - {{(MAX_ROWS-1){1'b0}}, 1'b1})) == '0;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// rtl/onehot_decoder.sv - combinational index to one-hot row decoder with enable
module onehot_decoder #(
    parameter int SEL_W = 5
) (
    input  logic                  en,
    input  logic [SEL_W-1:0]      sel,
    output logic [2**SEL_W-1:0]   row
);

    always_comb begin
        row = '0;
        if (en) begin
            row[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wr_decoder_pipe.sv
// rtl/regfile_wr_decoder_pipe.sv - multi-port write-enable decoder with port-priority arbitration,
// one output register stage, saturating collision counter and dirty bitmap
module regfile_wr_decoder_pipe
    import regfile_dec_pkg::*;
#(
    parameter int SEL_W     = 5,
    parameter int NUM_PORTS = 2,
    parameter int ZERO_HARD = 1,
    parameter int CNT_W     = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_PORTS-1:0]                   wr_valid,
    input  logic [NUM_PORTS-1:0][SEL_W-1:0]        wr_sel,
    input  logic                                   clr_dirty,
    output logic [NUM_PORTS-1:0][2**SEL_W-1:0]     en_row,
    output logic [2**SEL_W-1:0]                    en_any,
    output logic                                   collision,
    output logic [CNT_W-1:0]                       collision_cnt,
    output logic [2**SEL_W-1:0]                    dirty
);

    localparam int NROWS = 2 ** SEL_W;

    logic [NUM_PORTS-1:0]             live;
    logic [NUM_PORTS-1:0][NROWS-1:0]  dec_row;
    logic [NUM_PORTS-1:0][NROWS-1:0]  win_row;
    logic [NROWS-1:0]                 claimed;
    logic [NROWS-1:0]                 win_any;
    logic                             coll;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
        assign live[p] = wr_valid[p] && !((ZERO_HARD != 0) && (wr_sel[p] == '0));

        onehot_decoder #(.SEL_W(SEL_W)) u_dec (
            .en  (live[p]),
            .sel (wr_sel[p]),
            .row (dec_row[p])
        );
    end

    // Walk from the highest port down; a row already claimed by a higher port loses.
    always_comb begin
        claimed = '0;
        win_row = '0;
        win_any = '0;
        coll    = 1'b0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if ((dec_row[p] & claimed) != '0) begin
                coll = 1'b1;
            end else begin
                win_row[p] = dec_row[p];
            end
            claimed = claimed | dec_row[p];
            win_any = win_any | win_row[p];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_row        <= '0;
            en_any        <= '0;
            collision     <= 1'b0;
            collision_cnt <= '0;
            dirty         <= '0;
        end else begin
            en_row    <= win_row;
            en_any    <= win_any;
            collision <= coll;
            if (coll && (collision_cnt != {CNT_W{1'b1}})) begin
                collision_cnt <= collision_cnt + CNT_W'(1);
            end
            // A write in the clearing cycle survives the clear.
            dirty <= (clr_dirty ? '0 : dirty) | win_any;
        end
    end

endmodule
